// File: rtl/tiny_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tiny_cpu_run_ctrl
// Brief   : Run/halt/single-step clock-enable controller with one PC breakpoint
// Revision: 1.0
// ============================================================================
module tiny_cpu_run_ctrl #(
  parameter int PC_W    = 5,
  parameter int CNT_W   = 16,
  parameter bit AUTORUN = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cmd_valid_i,
  input  logic [1:0]       cmd_op_i,
  input  logic [PC_W:0]    cmd_arg_i,
  output logic             cmd_ready_o,
  input  logic [PC_W-1:0]  cpu_pc_i,
  input  logic             cpu_fetch_i,
  output logic             cpu_en_o,
  output logic             halted_o,
  output logic             bp_hit_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam logic [1:0] OP_HALT   = 2'b00;
  localparam logic [1:0] OP_RUN    = 2'b01;
  localparam logic [1:0] OP_STEP   = 2'b10;
  localparam logic [1:0] OP_SET_BP = 2'b11;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  localparam state_e RESET_STATE = AUTORUN ? ST_RUN : ST_HALTED;

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              halted_q, halted_d;
  logic              bp_hit_q, bp_hit_d;
  logic              bp_valid_q, bp_valid_d;
  logic [PC_W-1:0]   bp_addr_q, bp_addr_d;
  logic              bp_skip_q, bp_skip_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              cmd_acc;
  logic              bp_match;
  logic              cpu_en;
  logic              fetch_en;

  assign cmd_acc  = cmd_valid_i & ready_q;
  assign bp_match = bp_valid_q & cpu_fetch_i & (cpu_pc_i == bp_addr_q) & ~bp_skip_q;
  assign fetch_en = cpu_en & cpu_fetch_i;

  // The enable must react to a breakpoint in the same cycle, so it is decoded, not registered.
  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      ST_RUN:   cpu_en = ~bp_match;
      ST_STEP:  cpu_en = 1'b1;
      ST_DRAIN: cpu_en = 1'b1;
      default:  cpu_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    bp_hit_d   = bp_hit_q;
    bp_valid_d = bp_valid_q;
    bp_addr_d  = bp_addr_q;
    bp_skip_d  = bp_skip_q;
    cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, fetch_en};

    if (fetch_en) begin
      bp_skip_d = 1'b0;
    end

    case (state_q)
      ST_HALTED: begin
        if (cmd_acc && (cmd_op_i == OP_RUN || cmd_op_i == OP_STEP)) begin
          state_d   = (cmd_op_i == OP_RUN) ? ST_RUN : ST_STEP;
          bp_hit_d  = 1'b0;
          bp_skip_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (bp_match) begin
          state_d  = ST_HALTED;
          bp_hit_d = 1'b1;
        end else if (cmd_acc && (cmd_op_i == OP_HALT || cmd_op_i == OP_STEP)) begin
          // A fetch completing this edge leaves the core mid-instruction; finish it first.
          state_d = cpu_fetch_i ? ST_DRAIN : ST_HALTED;
        end
      end
      ST_STEP:  state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_HALTED;
      default:  state_d = RESET_STATE;
    endcase

    if (cmd_acc && cmd_op_i == OP_SET_BP) begin
      bp_valid_d = cmd_arg_i[PC_W];
      bp_addr_d  = cmd_arg_i[PC_W-1:0];
    end

    ready_d  = (state_d == ST_HALTED) || (state_d == ST_RUN);
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= RESET_STATE;
      ready_q    <= 1'b1;
      halted_q   <= ~AUTORUN;
      bp_hit_q   <= 1'b0;
      bp_valid_q <= 1'b0;
      bp_addr_q  <= '0;
      bp_skip_q  <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      halted_q   <= halted_d;
      bp_hit_q   <= bp_hit_d;
      bp_valid_q <= bp_valid_d;
      bp_addr_q  <= bp_addr_d;
      bp_skip_q  <= bp_skip_d;
      cnt_q      <= cnt_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign cpu_en_o    = cpu_en;
  assign halted_o    = halted_q;
  assign bp_hit_o    = bp_hit_q;
  assign instr_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tiny_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_tiny_cpu_run_ctrl
// Brief   : Directed bench for tiny_cpu_run_ctrl driving a 3->4->5->3 loop core
// Revision: 1.0
// ============================================================================
module tb_tiny_cpu_run_ctrl;

  localparam logic [1:0] OP_HALT   = 2'b00;
  localparam logic [1:0] OP_RUN    = 2'b01;
  localparam logic [1:0] OP_STEP   = 2'b10;
  localparam logic [1:0] OP_SET_BP = 2'b11;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_arg;
  logic        cmd_ready;
  logic [4:0]  cpu_pc;
  logic        cpu_fetch;
  logic        cpu_en;
  logic        halted;
  logic        bp_hit;
  logic [15:0] instr_cnt;

  logic        reset2;
  logic        cmd2_valid;
  logic [1:0]  cmd2_op;
  logic        cmd2_ready;
  logic        cpu_en2;
  logic        halted2;
  logic        bp_hit2;
  logic [2:0]  instr_cnt2;

  int n_vec = 0;
  int n_err = 0;

  tiny_cpu_run_ctrl #(.PC_W(5), .CNT_W(16), .AUTORUN(1'b1)) u_dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .cmd_valid_i (cmd_valid),
    .cmd_op_i    (cmd_op),
    .cmd_arg_i   (cmd_arg),
    .cmd_ready_o (cmd_ready),
    .cpu_pc_i    (cpu_pc),
    .cpu_fetch_i (cpu_fetch),
    .cpu_en_o    (cpu_en),
    .halted_o    (halted),
    .bp_hit_o    (bp_hit),
    .instr_cnt_o (instr_cnt)
  );

  // Narrow counter, halted out of reset, core parked permanently in fetch.
  tiny_cpu_run_ctrl #(.PC_W(5), .CNT_W(3), .AUTORUN(1'b0)) u_wrap (
    .clk_i       (clk),
    .reset_i     (reset2),
    .cmd_valid_i (cmd2_valid),
    .cmd_op_i    (cmd2_op),
    .cmd_arg_i   (6'd0),
    .cmd_ready_o (cmd2_ready),
    .cpu_pc_i    (5'd0),
    .cpu_fetch_i (1'b1),
    .cpu_en_o    (cpu_en2),
    .halted_o    (halted2),
    .bp_hit_o    (bp_hit2),
    .instr_cnt_o (instr_cnt2)
  );

  // Two-phase core: fetch then exec; program runs 0,1,2 then loops 3->4->5->3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_pc    <= 5'd0;
      cpu_fetch <= 1'b1;
    end else if (cpu_en) begin
      if (cpu_fetch) begin
        cpu_fetch <= 1'b0;
      end else begin
        cpu_fetch <= 1'b1;
        cpu_pc    <= (cpu_pc == 5'd5) ? 5'd3 : cpu_pc + 5'd1;
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_step(input logic [4:0] exp_pc, input logic [15:0] exp_cnt);
    send(OP_STEP, 6'd0);
    check("step_en_c1", cpu_en, 1);
    check("step_rdy_c1", cmd_ready, 0);
    check("step_halted_c1", halted, 0);
    check("step_bphit", bp_hit, 0);
    tick();
    check("step_en_c2", cpu_en, 1);
    check("step_rdy_c2", cmd_ready, 0);
    tick();
    check("step_halted", halted, 1);
    check("step_en_off", cpu_en, 0);
    check("step_rdy", cmd_ready, 1);
    check("step_pc", cpu_pc, exp_pc);
    check("step_fetch", cpu_fetch, 1);
    check("step_cnt", instr_cnt, exp_cnt);
  endtask

  initial begin
    reset      = 1'b1;
    reset2     = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = OP_HALT;
    cmd_arg    = 6'd0;
    cmd2_valid = 1'b0;
    cmd2_op    = OP_HALT;
    #2;
    check("rst_cpu_en", cpu_en, 1);
    check("rst_halted", halted, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_bp_hit", bp_hit, 0);
    check("rst_cnt", instr_cnt, 0);
    check("rst2_halted", halted2, 1);
    check("rst2_cpu_en", cpu_en2, 0);
    check("rst2_ready", cmd2_ready, 1);

    // Counter wrap on the narrow instance
    tick();
    reset2 = 1'b0;
    tick();
    tick();
    check("w_idle_cnt", instr_cnt2, 0);
    check("w_idle_en", cpu_en2, 0);
    cmd2_valid = 1'b1;
    cmd2_op    = OP_RUN;
    tick();
    cmd2_valid = 1'b0;
    check("w_run_halted", halted2, 0);
    check("w_run_en", cpu_en2, 1);
    check("w_bp_hit", bp_hit2, 0);
    repeat (7) tick();
    check("w_cnt_max", instr_cnt2, 7);
    tick();
    check("w_cnt_wrap", instr_cnt2, 0);
    repeat (3) tick();
    check("w_cnt_3", instr_cnt2, 3);
    reset2 = 1'b1;
    #1;
    check("w_async_cnt", instr_cnt2, 0);
    check("w_async_halted", halted2, 1);
    check("w_async_en", cpu_en2, 0);

    // Free run after reset
    reset = 1'b0;
    tick();
    check("run_cnt1", instr_cnt, 1);
    check("run_halted", halted, 0);
    check("run_en", cpu_en, 1);
    tick();
    tick();
    check("run_cnt2", instr_cnt, 2);
    check("run_pc1", cpu_pc, 1);

    // Breakpoint at PC 4
    send(OP_SET_BP, 6'b1_00100);
    repeat (4) tick();
    check("bp_en_low", cpu_en, 0);
    check("bp_not_yet_halted", halted, 0);
    check("bp_pc", cpu_pc, 4);
    tick();
    check("bp_halted", halted, 1);
    check("bp_hit", bp_hit, 1);
    check("bp_cnt", instr_cnt, 4);
    check("bp_fetch", cpu_fetch, 1);
    repeat (2) tick();
    check("bp_cnt_frozen", instr_cnt, 4);
    check("bp_pc_frozen", cpu_pc, 4);
    check("bp_en_frozen", cpu_en, 0);

    // Resume over the breakpoint, stop again one loop later
    send(OP_RUN, 6'd0);
    check("resume_bphit_clr", bp_hit, 0);
    check("resume_en", cpu_en, 1);
    repeat (6) tick();
    check("rebp_en_low", cpu_en, 0);
    check("rebp_pc", cpu_pc, 4);
    tick();
    check("rebp_halted", halted, 1);
    check("rebp_hit", bp_hit, 1);
    check("rebp_cnt", instr_cnt, 7);

    // Single steps 4->5->3->4
    do_step(5'd5, 16'd8);
    do_step(5'd3, 16'd9);
    do_step(5'd4, 16'd10);

    // HALT on a fetch cycle goes through DRAIN
    send(OP_RUN, 6'd0);
    check("hf_fetch", cpu_fetch, 1);
    send(OP_HALT, 6'd0);
    check("hf_drain_halted", halted, 0);
    check("hf_drain_rdy", cmd_ready, 0);
    check("hf_drain_en", cpu_en, 1);
    tick();
    check("hf_halted", halted, 1);
    check("hf_en", cpu_en, 0);
    check("hf_pc", cpu_pc, 5);
    check("hf_fetch_end", cpu_fetch, 1);
    check("hf_cnt", instr_cnt, 11);

    // HALT on an exec cycle stops directly
    send(OP_RUN, 6'd0);
    tick();
    check("he_exec", cpu_fetch, 0);
    send(OP_HALT, 6'd0);
    check("he_halted", halted, 1);
    check("he_en", cpu_en, 0);
    check("he_pc", cpu_pc, 3);
    check("he_fetch", cpu_fetch, 1);
    check("he_cnt", instr_cnt, 12);

    // HALT together with a breakpoint match: breakpoint wins
    send(OP_RUN, 6'd0);
    tick();
    tick();
    check("hb_en_low", cpu_en, 0);
    send(OP_HALT, 6'd0);
    check("hb_halted", halted, 1);
    check("hb_hit", bp_hit, 1);
    check("hb_pc", cpu_pc, 4);
    check("hb_cnt", instr_cnt, 13);

    // SET_BP on a match cycle: old match stops, new address applies next
    send(OP_RUN, 6'd0);
    repeat (6) tick();
    check("sb_en_low", cpu_en, 0);
    check("sb_pc", cpu_pc, 4);
    send(OP_SET_BP, 6'b1_00011);
    check("sb_halted", halted, 1);
    check("sb_hit", bp_hit, 1);
    check("sb_cnt", instr_cnt, 16);
    send(OP_RUN, 6'd0);
    repeat (4) tick();
    check("nb_en_low", cpu_en, 0);
    check("nb_pc", cpu_pc, 3);
    tick();
    check("nb_halted", halted, 1);
    check("nb_cnt", instr_cnt, 18);

    // Asynchronous reset while draining a step
    send(OP_STEP, 6'd0);
    tick();
    check("rd_pre_rdy", cmd_ready, 0);
    check("rd_pre_halted", halted, 0);
    reset = 1'b1;
    #1;
    check("rd_en", cpu_en, 1);
    check("rd_halted", halted, 0);
    check("rd_rdy", cmd_ready, 1);
    check("rd_bp_hit", bp_hit, 0);
    check("rd_cnt", instr_cnt, 0);
    tick();
    reset = 1'b0;
    repeat (12) tick();
    check("rd_bp_cleared", halted, 0);
    check("rd_cnt_after", instr_cnt, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tiny_cpu_run_ctrl.md
# tiny_cpu_run_ctrl

Run/halt/single-step controller for the tiny 8-bit CPU core. It drives the core's clock enable, so the core advances only when this block permits. It stops the core only at instruction boundaries (fetch state). It also provides one PC breakpoint and a retired-instruction counter for the debug/host path.

## Interface

Parameters:
- PC_W, 5: width of the core program counter.
- CNT_W, 16: width of the retired-instruction counter.
- AUTORUN, 1: 1 = leave reset in RUN (free-running core), 0 = leave reset in HALTED.

Ports:
- clk  in  1  single clock, shared with the core.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd_valid  in  1  host command strobe.
- cmd_op  in  2  command opcode:
  - 00 HALT
  - 01 RUN
  - 10 STEP
  - 11 SET_BP
- cmd_arg  in  PC_W+1  SET_BP payload: MSB = breakpoint enable, low PC_W bits = breakpoint address.
- cmd_ready  out  1  command accepted on a cycle where cmd_valid & cmd_ready.
- cpu_pc  in  PC_W  current core PC.
- cpu_fetch  in  1  core is in the fetch state (instruction boundary).
- cpu_en  out  1  clock enable to the core; the core updates only on edges where it is 1.
- halted  out  1  controller is in HALTED.
- bp_hit  out  1  sticky; breakpoint stopped the core.
- instr_cnt  out  CNT_W  count of enabled fetch cycles.

## Operation

States: HALTED, RUN, STEP, DRAIN.

Outputs decoded from state:
- cmd_ready = (state != STEP && state != DRAIN).
- halted = (state == HALTED).

Breakpoint match:
- bp_match = bp_valid & cpu_fetch & (cpu_pc == bp_addr) & ~bp_skip.

cpu_en:
- RUN: cpu_en = ~bp_match.
- STEP, DRAIN: cpu_en = 1.
- HALTED: cpu_en = 0.

bp_skip:
- Set when entering RUN or STEP from a command.
- Cleared after the first enabled fetch cycle.
- Effect: resuming at the breakpoint PC executes that instruction.

Transitions:
- HALTED + RUN → RUN; bp_hit cleared.
- HALTED + STEP → STEP; bp_hit cleared.
- HALTED + HALT → no effect.
- STEP → DRAIN unconditionally. The STEP cycle is the fetch; breakpoints are ignored.
- DRAIN → HALTED unconditionally. The DRAIN cycle is the exec.
- RUN, bp_match → HALTED; bp_hit set; cpu_en is 0 that cycle, so the core stays at the fetch of bp_addr.
- RUN + HALT or STEP accepted, no bp_match:
  - if cpu_fetch=0 (exec completing this edge) → HALTED;
  - if cpu_fetch=1 (fetch completing this edge) → DRAIN.
- RUN + RUN → no effect.
- SET_BP, accepted in any ready state: bp_valid ← cmd_arg[PC_W], bp_addr ← cmd_arg[PC_W-1:0]. No state change.

instr_cnt:
- Increments by 1 on every edge where cpu_en & cpu_fetch.
- Wraps from all-ones to 0.
- Cleared only by reset.

Invariant: HALTED is entered only with the core at a fetch boundary.

## Timing

- Reset values:
  - state = RUN if AUTORUN else HALTED;
  - cpu_en = AUTORUN;
  - halted = ~AUTORUN;
  - cmd_ready = 1;
  - bp_hit = 0, bp_valid = 0, bp_addr = 0, bp_skip = 1;
  - instr_cnt = 0.
- Reset asserted mid-operation: all of the above take effect immediately (asynchronous). cpu_en drops to the reset value with no drain; the core is reset by the same reset.
- Command latency: accepted on edge N; the new state, and cpu_en, apply from cycle N+1.
- STEP from HALTED: cpu_en high exactly 2 cycles (N+1, N+2); halted high again at N+3; instr_cnt +1.
- HALT in RUN: cpu_en falls within at most 2 cycles after acceptance.
- Simultaneous HALT and bp_match in RUN: breakpoint wins; bp_hit=1, HALTED.
- SET_BP on a bp_match cycle: the match uses the old bp_addr/bp_valid; the new values apply from the next cycle.
- cmd_ready is low during STEP and DRAIN. The host must hold cmd_valid; commands are not dropped.

## Test plan

1. AUTORUN=1, reset released, no commands → cpu_en=1 continuously; instr_cnt = 1 after the first fetch, increments every 2 cycles; halted=0.
2. SET_BP arg {1,5'd4} while running a program looping 3→4→5→3 → halted=1 and bp_hit=1 with cpu_pc=4 and cpu_fetch=1; cpu_en=0; instr_cnt frozen.
3. From stop 2, RUN → the instruction at PC 4 executes (bp_skip); the core stops again at PC 4 one loop later; bp_hit=1.
4. HALTED at PC 3, STEP → cpu_en high 2 cycles, cmd_ready low 2 cycles, core at PC 4 in fetch, halted=1, instr_cnt +1, bp_hit=0.
5. RUN, HALT issued once on a fetch cycle and once on an exec cycle → stops via DRAIN (2 cycles) and directly (1 cycle) respectively; both end with cpu_fetch=1.
6. Assert reset while in DRAIN, and separately with instr_cnt=16'hFFFF before one more fetch → immediate reset values; in the second case the counter wraps to 0.
